// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and types for the multi-port register file
package rf_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NR_DEF = 2;
  localparam int NW_DEF = 2;
  localparam int PW_DEF = 2;

  // Register 0 is hard-wired: reads 0, never written, never reserved
  localparam int ZERO_REG = 0;

  typedef logic [PW_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/rf_pend_ctr.sv
// rtl/rf_pend_ctr.sv - saturating up/down pending-write counter for one register
module rf_pend_ctr
  import rf_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] cnt,
  output logic          sat
);

  logic do_inc;
  logic do_dec;

  // A full counter refuses new reservations; an empty one ignores unreserved writes
  assign sat    = &cnt;
  assign do_inc = inc && !sat;
  assign do_dec = dec && (cnt != '0);

  // Simultaneous reserve and release cancel out
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multi-port register file with pending-write scoreboard (optional RF_BYPASS_EN)
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rbusy,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*DW-1:0] wd,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_a,
  output logic             rsv_rdy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] wsel [DEPTH];
  logic [PW-1:0] cnt  [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] sat;

  assign hit[0]  = 1'b0;
  assign wsel[0] = '0;
  assign cnt[0]  = '0;
  assign sat[0]  = 1'b0;

  // Per-register write decode: a priority chain where the highest port index wins
  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    logic [NW:0]   h;
    logic [DW-1:0] d [NW+1];

    assign h[0] = 1'b0;
    assign d[0] = '0;

    for (genvar j = 0; j < NW; j++) begin : g_wp
      logic m;
      assign m      = we[j] && (wa[j*AW +: AW] == AW'(r));
      assign h[j+1] = h[j] | m;
      assign d[j+1] = m ? wd[j*DW +: DW] : d[j];
    end

    assign hit[r]  = h[NW];
    assign wsel[r] = d[NW];

    rf_pend_ctr #(.PW(PW)) u_ctr (
      .clk  (clk),
      .clear(rst),
      .inc  (rsv && (rsv_a == AW'(r))),
      .dec  (hit[r]),
      .cnt  (cnt[r]),
      .sat  (sat[r])
    );
  end

  // Reservation acceptance depends only on the addressed counter, not on rsv itself
  assign rsv_rdy = (rsv_a == AW'(ZERO_REG)) || !sat[rsv_a];

  // Storage update; entry 0 never has a hit, so it stays at its reset value of 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (hit[r]) mem[r] <= wsel[r];
      end
    end
  end

  // Read ports: stored data, optionally forwarded from this cycle's winning write
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[i*AW +: AW];
`ifdef RF_BYPASS_EN
    assign rd[i*DW +: DW] = hit[a] ? wsel[a] : mem[a];
    assign rbusy[i]       = (cnt[a] != '0) && !((cnt[a] == PW'(1)) && hit[a]);
`else
    assign rd[i*DW +: DW] = mem[a];
    assign rbusy[i]       = (cnt[a] != '0);
`endif
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - self-checking bench for rf_multiport (honours RF_BYPASS_EN)
module tb_rf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int PW = 2;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic             rsv;
  logic [AW-1:0]    rsv_a;
  logic             rsv_rdy;

  int checks = 0;
  int errors = 0;

  rf_multiport #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ra     (ra),
    .rd     (rd),
    .rbusy  (rbusy),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .rsv    (rsv),
    .rsv_a  (rsv_a),
    .rsv_rdy(rsv_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [4:0]  chk;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        busy;
    logic        rdy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] we_i, input logic [4:0] wa0_i, input logic [31:0] wd0_i,
                              input logic [4:0] wa1_i, input logic [31:0] wd1_i, input logic rsv_i,
                              input logic [4:0] rsv_a_i, input logic [4:0] chk_i, input logic [31:0] erd,
                              input logic ebusy, input logic erdy);
    vec_t v;
    v.we = we_i; v.wa0 = wa0_i; v.wd0 = wd0_i; v.wa1 = wa1_i; v.wd1 = wd1_i;
    v.rsv = rsv_i; v.rsv_a = rsv_a_i; v.chk = chk_i;
    v.exp_rd = erd; v.exp_busy = ebusy; v.exp_rdy = erdy;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    we = v.we; wa = {v.wa1, v.wa0}; wd = {v.wd1, v.wd0};
    rsv = v.rsv; rsv_a = v.rsv_a;
    e.idx = idx; e.rd = v.exp_rd; e.busy = v.exp_busy; e.rdy = v.exp_rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    we = '0; rsv = 1'b0; ra = {v.chk, v.chk};
    #1;
    g = sb.pop_front();
    chk($sformatf("vec%0d rd0", g.idx), rd[31:0], g.rd);
    chk($sformatf("vec%0d rd1", g.idx), rd[63:32], g.rd);
    chk($sformatf("vec%0d rbusy0", g.idx), 32'(rbusy[0]), 32'(g.busy));
    chk($sformatf("vec%0d rbusy1", g.idx), 32'(rbusy[1]), 32'(g.busy));
    chk($sformatf("vec%0d rsv_rdy", g.idx), 32'(rsv_rdy), 32'(g.rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset must win over the same-cycle write and reservation
    rst = 1'b1; we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'hDEADBEEF, 32'hDEADBEEF};
    rsv = 1'b1; rsv_a = 5'd3; ra = '0;
    @(posedge clk);
    #1;
    rst = 1'b0; we = '0; rsv = 1'b0; ra = {5'd3, 5'd3};
    #1;
    chk("reset rd0", rd[31:0], 32'h0);
    chk("reset rd1", rd[63:32], 32'h0);
    chk("reset rbusy", 32'(rbusy), 32'h0);
    chk("reset rsv_rdy", 32'(rsv_rdy), 32'h1);

    //           we     wa0    wd0           wa1    wd1          rsv  rsv_a  chk    exp_rd        busy rdy
    vecs.push_back(mk(2'b01, 5'd5,  32'h12345678, 5'd0,  32'h0,       1'b0, 5'd0,  5'd5,  32'h12345678, 1'b0, 1'b1));
    vecs.push_back(mk(2'b01, 5'd0,  32'h12345678, 5'd0,  32'h0,       1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(2'b11, 5'd7,  32'hAAAA,     5'd7,  32'hBBBB,    1'b0, 5'd0,  5'd7,  32'hBBBB,     1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd9,  5'd9,  32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd9,  5'd9,  32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(2'b10, 5'd0,  32'h0,        5'd9,  32'h99,      1'b0, 5'd9,  5'd9,  32'h99,       1'b1, 1'b1));
    vecs.push_back(mk(2'b01, 5'd9,  32'h9A,       5'd0,  32'h0,       1'b0, 5'd9,  5'd9,  32'h9A,       1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd10, 5'd10, 32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd10, 5'd10, 32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd10, 5'd10, 32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd10, 5'd10, 32'h0,        1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 5'd10, 32'hA0,       5'd0,  32'h0,       1'b1, 5'd10, 5'd10, 32'hA0,       1'b1, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd4,  5'd4,  32'h0,        1'b1, 1'b1));
    vecs.push_back(mk(2'b01, 5'd4,  32'h44,       5'd0,  32'h0,       1'b1, 5'd4,  5'd4,  32'h44,       1'b1, 1'b1));
    vecs.push_back(mk(2'b11, 5'd4,  32'h40,       5'd4,  32'h41,      1'b0, 5'd4,  5'd4,  32'h41,       1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,       1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 1'b1));
    vecs.push_back(mk(2'b11, 5'd6,  32'h66,       5'd5,  32'h55,      1'b0, 5'd0,  5'd6,  32'h66,       1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Same-cycle read of a register being written: forwarded only with bypass
    @(negedge clk);
    we = 2'b10; wa = {5'd6, 5'd0}; wd = {32'h55, 32'h0}; ra = {5'd0, 5'd6};
    #1;
    chk("bypass rd0 same cycle", rd[31:0], BYP ? 32'h55 : 32'h66);
    @(posedge clk);
    #1;
    we = '0;
    #1;
    chk("bypass rd0 next cycle", rd[31:0], 32'h55);

    // Last outstanding write clears rbusy early only with bypass
    @(negedge clk);
    rsv = 1'b1; rsv_a = 5'd6;
    @(posedge clk);
    #1;
    rsv = 1'b0;
    #1;
    chk("r6 busy after rsv", 32'(rbusy[0]), 32'h1);
    @(negedge clk);
    we = 2'b10; wa = {5'd6, 5'd0}; wd = {32'h77, 32'h0};
    #1;
    chk("r6 busy during write", 32'(rbusy[0]), BYP ? 32'h0 : 32'h1);
    @(posedge clk);
    #1;
    we = '0;
    #1;
    chk("r6 busy after write", 32'(rbusy[0]), 32'h0);
    chk("r6 data after write", rd[31:0], 32'h77);

    // Saturation without look-ahead: r10 is at 2, reserve to 3 then write
    @(negedge clk);
    rsv = 1'b1; rsv_a = 5'd10;
    @(posedge clk);
    #1;
    rsv = 1'b0;
    #1;
    chk("r10 sat rsv_rdy", 32'(rsv_rdy), 32'h0);
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'hA1};
    #1;
    chk("r10 rsv_rdy during write", 32'(rsv_rdy), 32'h0);
    @(posedge clk);
    #1;
    we = '0;
    #1;
    chk("r10 rsv_rdy after write", 32'(rsv_rdy), 32'h1);

    // Mid-operation reset discards reservations; later writes are unreserved
    @(negedge clk);
    rsv = 1'b1; rsv_a = 5'd12; ra = {5'd0, 5'd12};
    @(posedge clk);
    #1;
    rsv = 1'b0;
    #1;
    chk("r12 busy before rst", 32'(rbusy[0]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; ra = {5'd6, 5'd12};
    #1;
    chk("r12 busy after rst", 32'(rbusy[0]), 32'h0);
    chk("r6 data after rst", rd[63:32], 32'h0);
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'hC};
    @(posedge clk);
    #1;
    we = '0;
    #1;
    chk("r12 unreserved write data", rd[31:0], 32'hC);
    chk("r12 unreserved write busy", 32'(rbusy[0]), 32'h0);
    @(negedge clk);
    rsv = 1'b1; rsv_a = 5'd12;
    @(posedge clk);
    #1;
    rsv = 1'b0;
    #1;
    chk("r12 busy after fresh rsv", 32'(rbusy[0]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port register file for the pipelined CPU: a generalisation of the single-write, dual-read file with configurable width, depth, read-port and write-port count. It adds a per-register pending-write scoreboard: the issue stage reserves a destination, and writeback releases it. Each read port reports whether its operand is still pending, so hazard logic can stall without tracking destinations itself. It sits between decode/issue and the writeback stage(s).

## Interface
- DW, 32, data width
- AW, 5, address width; depth = 2^AW registers
- NR, 2, number of read ports
- NW, 2, number of write ports; a higher index has priority on address collision
- PW, 2, pending-counter width per register; saturates at 2^PW-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  NR*AW  read addresses; port i is slice [i*AW +: AW]
- rd  out  NR*DW  read data, combinational from ra
- rbusy  out  NR  read port i's register has pending writes
- we  in  NW  write enables
- wa  in  NW*AW  write addresses
- wd  in  NW*DW  write data
- rsv  in  1  reserve request for rsv_a
- rsv_a  in  AW  register being reserved
- rsv_rdy  out  1  reservation can be accepted (counter for rsv_a not saturated)

## Operation
- Register 0:
  - reads as 0
  - writes are ignored
  - never busy
  - rsv to 0 is ignored
  - rsv_rdy is 1 when rsv_a=0
- Write: on posedge, if we[j] and wa[j]!=0, then reg[wa[j]] <= wd[j]. On address collision, only the highest j is written.
- Pending counter cnt[r], updated on each posedge:
  - inc = rsv && rsv_rdy && rsv_a==r && r!=0
  - dec = (any we[j] with wa[j]==r) && cnt[r]!=0; multiple ports hitting r decrement once only
  - inc&&dec: unchanged; inc only: +1; dec only: -1
  - A write to a register with cnt=0 updates data and leaves cnt at 0.
- rsv with rsv_rdy=0 is dropped with no state change; the requester must hold rsv until rsv_rdy=1.
- rbusy[i] = cnt[ra_i]!=0, subject to the bypass rule in Configuration.
- rst has priority over every same-cycle we/rsv. On rst, all registers and all counters clear to 0.

## Timing
- Read latency is 0 (combinational). Write latency is 1: written data becomes visible to reads the cycle after we, unless bypass is compiled in.
- Reset values:
  - rd = 0 for all ports after the reset edge
  - rbusy = 0
  - rsv_rdy = 1
- rsv_rdy is combinational from rsv_a and cnt and does not depend on rsv.
- Reservation takes effect at the next edge: rbusy for that register rises the cycle after the rsv handshake.
- Saturation: when cnt = 2^PW-1, rsv_rdy=0. If a write to that register occurs in the same cycle, rsv_rdy stays 0 that cycle; no look-ahead.
- A rst asserted mid-operation discards all pending reservations; the writes that were expected to follow are then treated as unreserved writes.

## Configuration
- RF_BYPASS_EN defined:
  - A read whose address matches an active write this cycle returns the highest-priority matching wd (address 0 excluded).
  - rbusy[i] is additionally cleared when cnt[ra_i]==1 and that register is being written this cycle.
- RF_BYPASS_EN undefined:
  - rd shows stored contents only.
  - rbusy is purely cnt!=0.
  - The pipeline must stall one extra cycle on write-read collisions.

## Structure
- Package rf_pkg holds:
  - default DW/AW/NR/NW/PW
  - ZERO_REG = 0
  - a typedef for the per-register counter
- Sub-module rf_pend_ctr: one saturating up/down counter with inc, dec, clear and a sat flag. It is instantiated for registers 1..2^AW-1.
- Write-priority and bypass select are generate loops in the top module.

## Test plan
- Reset: rst for 1 cycle with we=all-1, wa=3, wd=0xDEADBEEF → reg3 reads 0, all rbusy=0, rsv_rdy=1.
- Basic write/read: we[0], wa=5, wd=0x12345678 → next cycle ra0=5 gives 0x12345678. The same write to address 0 → ra=0 reads 0.
- Collision: we=2'b11, wa0=wa1=7, wd0=0xAAAA, wd1=0xBBBB → reg7 = 0xBBBB.
- Scoreboard:
  - rsv r9 twice → cnt=2, rbusy=1
  - one write → still busy
  - second write → rbusy=0
  - with PW=2, three rsv → rsv_rdy=0; a fourth rsv is dropped
- Simultaneous events: rsv r4 in the same cycle as a write to r4 with cnt=1 → cnt remains 1 and rbusy stays 1.
- Bypass (RF_BYPASS_EN): we[1], wa=6, wd=0x55 with ra0=6 in the same cycle → rd0=0x55. Without the macro → old value.
